calc_result_reader: RTL and testbench

//  Consumer end of the simple-calculator result interface.
//  - Watches the calculator's one-hot QDone/QErr/QI state bits.
//  - Captures the 17-bit result C and Flag when the calculator reaches DONE.
//  - Converts C to packed BCD with a sequential double-dabble, one bit per cycle.
//  - Presents digits, overflow, error and leading-zero blank mask to the 7-segment display driver.

---
 rtl/calc_result_reader_if.sv | 13 +
 rtl/calc_result_reader.sv | 109 ++++++++++
 tb/tb_calc_result_reader.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/calc_result_reader_if.sv
// rtl/calc_result_reader_if.sv - calculator result/state bits seen by the result reader
interface calc_result_reader_if #(
  parameter int WIDTH = 17
);
  logic             QDone;
  logic             QErr;
  logic             QI;
  logic [WIDTH-1:0] C;
  logic             Flag;

  modport master (output QDone, QErr, QI, C, Flag);
  modport slave  (input  QDone, QErr, QI, C, Flag);
endinterface

// File: rtl/calc_result_reader.sv
// rtl/calc_result_reader.sv - captures calculator result and converts it to BCD digits
// Sequential double-dabble, one bit per cycle, with leading-zero blank mask.
module calc_result_reader #(
  parameter int WIDTH  = 17,
  parameter int DIGITS = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  calc_result_reader_if.slave   calc,
  output logic [4*DIGITS-1:0]   Digits,
  output logic [DIGITS-1:0]     Blank,
  output logic                  Valid,
  output logic                  Busy,
  output logic                  Ovf,
  output logic                  Err
);
  localparam logic [3:0] IDLE  = 4'b0001;
  localparam logic [3:0] SHIFT = 4'b0010;
  localparam logic [3:0] SHOW  = 4'b0100;
  localparam logic [3:0] ERROR = 4'b1000;

  localparam int                CNT_W     = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT  = CNT_W'(WIDTH - 1);
  localparam logic [DIGITS-1:0] BLANK_RST = {{(DIGITS-1){1'b1}}, 1'b0};

  logic [3:0]          state;
  logic                qdone_d;
  logic [WIDTH-1:0]    sreg;
  logic [4*DIGITS-1:0] acc;
  logic [CNT_W-1:0]    cnt;

  logic [4*DIGITS-1:0] acc_adj;
  logic [4*DIGITS-1:0] acc_shf;
  logic [WIDTH-1:0]    sreg_shf;
  logic [DIGITS-1:0]   blank_shf;
  logic                zero_above;
  logic                rise;

  assign rise = calc.QDone & ~qdone_d;

  always_comb begin
    acc_adj = acc;
    for (int i = 0; i < DIGITS; i++) begin
      if (acc[4*i +: 4] >= 4'd5)
        acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
    end
    {acc_shf, sreg_shf} = {acc_adj[4*DIGITS-2:0], sreg, 1'b0};
    // A digit is blanked only when it and every more significant digit are zero
    zero_above = 1'b1;
    blank_shf  = '0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_above   = zero_above & (acc_shf[4*k +: 4] == 4'd0);
      blank_shf[k] = zero_above;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= IDLE;
      qdone_d <= 1'b0;
      sreg    <= '0;
      acc     <= '0;
      cnt     <= '0;
      Digits  <= '0;
      Blank   <= BLANK_RST;
      Valid   <= 1'b0;
      Busy    <= 1'b0;
      Ovf     <= 1'b0;
      Err     <= 1'b0;
    end else begin
      qdone_d <= calc.QDone;
      if (calc.QI) begin
        state  <= IDLE;
        Valid  <= 1'b0;
        Busy   <= 1'b0;
        Err    <= 1'b0;
        Ovf    <= 1'b0;
        Digits <= '0;
        Blank  <= BLANK_RST;
      end else if (calc.QErr) begin
        state  <= ERROR;
        Err    <= 1'b1;
        Valid  <= 1'b0;
        Busy   <= 1'b0;
        Digits <= '0;
        Blank  <= BLANK_RST;
      end else if (rise && state != ERROR) begin
        state <= SHIFT;
        sreg  <= calc.C;
        acc   <= '0;
        cnt   <= '0;
        Ovf   <= calc.Flag;
        Busy  <= 1'b1;
        Valid <= 1'b0;
      end else if (state == SHIFT) begin
        acc  <= acc_shf;
        sreg <= sreg_shf;
        cnt  <= cnt + 1'b1;
        if (cnt == LAST_CNT) begin
          Digits <= acc_shf;
          Blank  <= blank_shf;
          Valid  <= 1'b1;
          Busy   <= 1'b0;
          state  <= SHOW;
        end
      end
    end
  end
endmodule

// File: tb/tb_calc_result_reader.sv
// tb/tb_calc_result_reader.sv - directed self-checking bench for calc_result_reader
module tb_calc_result_reader;
  logic        Clk = 1'b0;
  logic        Reset;
  logic [23:0] Digits;
  logic [5:0]  Blank;
  logic        Valid, Busy, Ovf, Err;

  int compared   = 0;
  int mismatched = 0;
  int n;
  int busy_cycles, windows;
  logic busy_prev;

  calc_result_reader_if #(.WIDTH(17)) calc_if ();

  calc_result_reader #(.WIDTH(17), .DIGITS(6)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .calc   (calc_if.slave),
    .Digits (Digits),
    .Blank  (Blank),
    .Valid  (Valid),
    .Busy   (Busy),
    .Ovf    (Ovf),
    .Err    (Err)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (Busy && cycles < 40) begin
      tick();
      cycles++;
    end
  endtask

  task automatic start(input logic [16:0] c, input logic flag);
    calc_if.QDone = 1'b0;
    tick();
    calc_if.C     = c;
    calc_if.Flag  = flag;
    calc_if.QDone = 1'b1;
    tick();
  endtask

  initial begin
    Reset         = 1'b1;
    calc_if.QDone = 1'b0;
    calc_if.QErr  = 1'b0;
    calc_if.QI    = 1'b0;
    calc_if.C     = '0;
    calc_if.Flag  = 1'b0;
    tick();
    tick();
    check("rst_digits", Digits, 32'h0);
    check("rst_blank",  Blank,  6'b111110);
    check("rst_valid",  Valid,  0);
    check("rst_busy",   Busy,   0);
    check("rst_ovf",    Ovf,    0);
    check("rst_err",    Err,    0);
    Reset = 1'b0;
    tick();

    // 1: 12345
    start(17'd12345, 1'b0);
    check("t1_busy_start", Busy, 1);
    check("t1_valid_low",  Valid, 0);
    wait_done(n);
    check("t1_latency", n, 17);
    check("t1_digits",  Digits, 24'h012345);
    check("t1_blank",   Blank,  6'b100000);
    check("t1_valid",   Valid,  1);
    check("t1_ovf",     Ovf,    0);

    // 2: zero
    start(17'd0, 1'b0);
    calc_if.QDone = 1'b0;
    wait_done(n);
    check("t2_digits", Digits, 24'h000000);
    check("t2_blank",  Blank,  6'b111110);
    check("t2_valid",  Valid,  1);

    // 3: max value with flag
    start(17'h1FFFF, 1'b1);
    wait_done(n);
    check("t3_digits", Digits, 24'h131071);
    check("t3_blank",  Blank,  6'b000000);
    check("t3_ovf",    Ovf,    1);

    // 4: QDone held high for 100 cycles gives one conversion
    calc_if.QDone = 1'b0;
    tick();
    calc_if.C     = 17'd500;
    calc_if.Flag  = 1'b0;
    calc_if.QDone = 1'b1;
    busy_cycles = 0;
    windows     = 0;
    busy_prev   = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (Busy) busy_cycles++;
      if (Busy && !busy_prev) windows++;
      busy_prev = Busy;
    end
    check("t4_windows",     windows,     1);
    check("t4_busy_cycles", busy_cycles, 17);
    check("t4_valid",       Valid,       1);
    check("t4_digits",      Digits,      24'h000500);
    start(17'd7, 1'b0);
    check("t4_valid_drop", Valid, 0);
    check("t4_busy",       Busy,  1);
    wait_done(n);
    check("t4_latency", n,      17);
    check("t4_digits7", Digits, 24'h000007);
    check("t4_blank7",  Blank,  6'b111110);

    // 5: QErr mid-conversion, then QI
    start(17'd12345, 1'b1);
    repeat (7) tick();
    check("t5_busy_mid", Busy, 1);
    calc_if.QErr = 1'b1;
    tick();
    calc_if.QErr = 1'b0;
    check("t5_err",    Err,    1);
    check("t5_busy",   Busy,   0);
    check("t5_valid",  Valid,  0);
    check("t5_digits", Digits, 24'h000000);
    check("t5_blank",  Blank,  6'b111110);
    repeat (20) tick();
    check("t5_err_hold",   Err,   1);
    check("t5_valid_hold", Valid, 0);
    calc_if.QI = 1'b1;
    tick();
    calc_if.QI = 1'b0;
    check("t5_qi_err", Err,   0);
    check("t5_qi_ovf", Ovf,   0);
    check("t5_qi_bsy", Busy,  0);

    // 6: asynchronous reset mid-conversion
    start(17'd4321, 1'b1);
    repeat (4) tick();
    check("t6_busy_mid", Busy, 1);
    Reset = 1'b1;
    calc_if.QDone = 1'b0;
    #1;
    check("t6_rst_digits", Digits, 24'h000000);
    check("t6_rst_blank",  Blank,  6'b111110);
    check("t6_rst_busy",   Busy,   0);
    check("t6_rst_valid",  Valid,  0);
    check("t6_rst_ovf",    Ovf,    0);
    tick();
    Reset = 1'b0;
    tick();
    start(17'd99, 1'b0);
    wait_done(n);
    check("t6_latency", n,      17);
    check("t6_digits",  Digits, 24'h000099);
    check("t6_blank",   Blank,  6'b111100);
    check("t6_valid",   Valid,  1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
